// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state encoding,
// instruction field constants and ALU selector codes.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } ctrlStateT;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_control_fsm_alu_decoder.sv
// Maps a latched opcode/funct pair to the ALU operation and flags whether the
// pair belongs to the supported instruction subset.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] aluSel,
  output logic       legal
);

  always_comb begin
    aluSel = ALU_AND;
    legal  = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  aluSel = ALU_ADD;
          FN_SUB:  aluSel = ALU_SUB;
          FN_AND:  aluSel = ALU_AND;
          FN_OR:   aluSel = ALU_OR;
          FN_SLT:  aluSel = ALU_SLT;
          default: legal  = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: aluSel = ALU_ADD;
      OP_ANDI: aluSel = ALU_AND;
      OP_ORI:  aluSel = ALU_OR;
      OP_BEQ:  aluSel = ALU_SUB;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_control_fsm.sv
// Multi-cycle MIPS control FSM: IDLE/FETCH/DECODE/EXEC/MEM/WB with a sticky
// TRAP for illegal instructions and data-memory timeouts.
module mips_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       MemaReg,
  output logic       enWrSram,
  output logic       enWriteMemory,
  output logic       ftePC,
  output logic       enablePC,
  output logic       fteALU,
  output logic       regDst,
  output logic [2:0] ALUSelector,
  output logic       instr_done,
  output logic       illegal,
  output logic       mem_timeout
);

  localparam int unsigned CW = $clog2(MEM_WAIT_MAX + 1);

  ctrlStateT     state, nxtState;
  logic [5:0]    opQ, fnQ;
  logic          zeroQ, nxtZero;
  logic [CW-1:0] waitCnt;
  logic [2:0]    decAlu;
  logic          decLegal;

  logic isR, isLw, isSw, isBeq, isAluImm;

  logic       nMemaReg, nEnWrSram, nEnWriteMemory, nFtePC, nEnablePC;
  logic       nFteALU, nRegDst, nInstrDone;
  logic [2:0] nAluSel;

  alu_decoder uDec (
    .opcode (opQ),
    .funct  (fnQ),
    .aluSel (decAlu),
    .legal  (decLegal)
  );

  assign isR      = (opQ == OP_RTYPE);
  assign isLw     = (opQ == OP_LW);
  assign isSw     = (opQ == OP_SW);
  assign isBeq    = (opQ == OP_BEQ);
  assign isAluImm = (opQ == OP_ADDI) || (opQ == OP_ANDI) || (opQ == OP_ORI);

  // mem_ready takes priority over the final wait cycle expiring.
  always_comb begin
    nxtState = state;
    nxtZero  = zeroQ;
    case (state)
      IDLE:   if (run) nxtState = FETCH;
      FETCH:  nxtState = DECODE;
      DECODE: nxtState = decLegal ? EXEC : TRAP;
      EXEC: begin
        if (isBeq) nxtZero = zero;
        nxtState = (isLw || isSw) ? MEM : WB;
      end
      MEM: begin
        if (mem_ready)                                nxtState = WB;
        else if (waitCnt == CW'(MEM_WAIT_MAX - 1))    nxtState = TRAP;
      end
      WB:     nxtState = run ? FETCH : IDLE;
      TRAP:   nxtState = TRAP;
      default: nxtState = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered;
  // opQ/fnQ are already stable whenever that state is EXEC, MEM or WB.
  always_comb begin
    nMemaReg       = 1'b0;
    nEnWrSram      = 1'b0;
    nEnWriteMemory = 1'b0;
    nFtePC         = 1'b0;
    nEnablePC      = 1'b0;
    nFteALU        = 1'b0;
    nRegDst        = 1'b0;
    nInstrDone     = 1'b0;
    nAluSel        = '0;
    case (nxtState)
      EXEC: begin
        nAluSel = decAlu;
        nRegDst = isR;
        nFteALU = !isR && !isBeq;
      end
      MEM: begin
        nAluSel        = decAlu;
        nFteALU        = 1'b1;
        nEnWriteMemory = isSw;
      end
      WB: begin
        nAluSel    = decAlu;
        nEnablePC  = 1'b1;
        nInstrDone = 1'b1;
        nEnWrSram  = isR || isAluImm || isLw;
        nMemaReg   = isLw;
        nRegDst    = isR;
        nFtePC     = isBeq && nxtZero;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      opQ           <= '0;
      fnQ           <= '0;
      zeroQ         <= 1'b0;
      waitCnt       <= '0;
      MemaReg       <= 1'b0;
      enWrSram      <= 1'b0;
      enWriteMemory <= 1'b0;
      ftePC         <= 1'b0;
      enablePC      <= 1'b0;
      fteALU        <= 1'b0;
      regDst        <= 1'b0;
      ALUSelector   <= '0;
      instr_done    <= 1'b0;
      illegal       <= 1'b0;
      mem_timeout   <= 1'b0;
    end else begin
      state <= nxtState;
      zeroQ <= nxtZero;
      if (state == FETCH) begin
        opQ <= opcode;
        fnQ <= funct;
      end
      waitCnt <= (state == MEM && nxtState == MEM) ? waitCnt + CW'(1) : '0;
      MemaReg       <= nMemaReg;
      enWrSram      <= nEnWrSram;
      enWriteMemory <= nEnWriteMemory;
      ftePC         <= nFtePC;
      enablePC      <= nEnablePC;
      fteALU        <= nFteALU;
      regDst        <= nRegDst;
      ALUSelector   <= nAluSel;
      instr_done    <= nInstrDone;
      if (state == DECODE && nxtState == TRAP) illegal     <= 1'b1;
      if (state == MEM    && nxtState == TRAP) mem_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_control_fsm.sv
// Directed bench for mips_control_fsm: table of single-cycle-class instructions
// plus hand sequences for memory wait, timeout, traps, run drop and reset.
module tb_mips_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       MemaReg, enWrSram, enWriteMemory, ftePC, enablePC, fteALU, regDst;
  logic [2:0] ALUSelector;
  logic       instr_done, illegal, mem_timeout;

  // {MemaReg,enWrSram,enWriteMemory,ftePC,enablePC,fteALU,regDst,ALU[2:0],instr_done,illegal,mem_timeout}
  logic [12:0] outs;
  assign outs = {MemaReg, enWrSram, enWriteMemory, ftePC, enablePC, fteALU, regDst,
                 ALUSelector, instr_done, illegal, mem_timeout};

  int nTests = 0;
  int nFail  = 0;

  mips_control_fsm #(.MEM_WAIT_MAX(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .opcode        (opcode),
    .funct         (funct),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .MemaReg       (MemaReg),
    .enWrSram      (enWrSram),
    .enWriteMemory (enWriteMemory),
    .ftePC         (ftePC),
    .enablePC      (enablePC),
    .fteALU        (fteALU),
    .regDst        (regDst),
    .ALUSelector   (ALUSelector),
    .instr_done    (instr_done),
    .illegal       (illegal),
    .mem_timeout   (mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic [12:0] expExec;
    logic [12:0] expWb;
  } vecT;

  vecT vecs[11];

  localparam logic [12:0] ZERO_OUT = 13'b0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic asyncReset;
    #2 rst = 1'b0;
    #1 check("async reset clears", outs, ZERO_OUT);
    run = 1'b0;
    mem_ready = 1'b0;
    tick;
    rst = 1'b1;
  endtask

  task automatic illegalTrap(input string name, input logic [5:0] op, input logic [5:0] fn);
    run = 1'b1; opcode = op; funct = fn;
    tick;
    run = 1'b0;
    tick;
    check({name, " decode"}, outs, ZERO_OUT);
    tick;
    check({name, " trap"}, outs, 13'b0_0_0_0_0_0_0_000_0_1_0);
    run = 1'b1;
    tick;
    check({name, " trap hold"}, outs, 13'b0_0_0_0_0_0_0_000_0_1_0);
    asyncReset;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] acc;

    vecs[0]  = '{"add",   6'h00, 6'h20, 1'b0, 13'b0_0_0_0_0_0_1_010_0_0_0, 13'b0_1_0_0_1_0_1_010_1_0_0};
    vecs[1]  = '{"sub",   6'h00, 6'h22, 1'b0, 13'b0_0_0_0_0_0_1_110_0_0_0, 13'b0_1_0_0_1_0_1_110_1_0_0};
    vecs[2]  = '{"and",   6'h00, 6'h24, 1'b1, 13'b0_0_0_0_0_0_1_000_0_0_0, 13'b0_1_0_0_1_0_1_000_1_0_0};
    vecs[3]  = '{"or",    6'h00, 6'h25, 1'b0, 13'b0_0_0_0_0_0_1_001_0_0_0, 13'b0_1_0_0_1_0_1_001_1_0_0};
    vecs[4]  = '{"slt",   6'h00, 6'h2A, 1'b0, 13'b0_0_0_0_0_0_1_111_0_0_0, 13'b0_1_0_0_1_0_1_111_1_0_0};
    vecs[5]  = '{"addi",  6'h08, 6'h15, 1'b0, 13'b0_0_0_0_0_1_0_010_0_0_0, 13'b0_1_0_0_1_0_0_010_1_0_0};
    vecs[6]  = '{"andi",  6'h0C, 6'h2A, 1'b1, 13'b0_0_0_0_0_1_0_000_0_0_0, 13'b0_1_0_0_1_0_0_000_1_0_0};
    vecs[7]  = '{"ori",   6'h0D, 6'h00, 1'b0, 13'b0_0_0_0_0_1_0_001_0_0_0, 13'b0_1_0_0_1_0_0_001_1_0_0};
    vecs[8]  = '{"beq z1",6'h04, 6'h20, 1'b1, 13'b0_0_0_0_0_0_0_110_0_0_0, 13'b0_0_0_1_1_0_0_110_1_0_0};
    vecs[9]  = '{"beq z0",6'h04, 6'h20, 1'b0, 13'b0_0_0_0_0_0_0_110_0_0_0, 13'b0_0_0_0_1_0_0_110_1_0_0};
    vecs[10] = '{"lw-fn", 6'h00, 6'h24, 1'b0, 13'b0_0_0_0_0_0_1_000_0_0_0, 13'b0_1_0_0_1_0_1_000_1_0_0};

    rst = 1'b1; run = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    #2 rst = 1'b0;
    #1 check("reset state", outs, ZERO_OUT);
    tick; tick;
    rst = 1'b1;
    tick;
    check("idle after reset", outs, ZERO_OUT);

    illegalTrap("op 3F", 6'h3F, 6'h00);
    illegalTrap("rtype fn 21", 6'h00, 6'h21);

    // Table: ALU and branch instructions, 4 cycles FETCH..WB, then IDLE.
    for (int i = 0; i < 11; i++) begin
      zero = ~vecs[i].z; run = 1'b1; opcode = '0; funct = '0;
      tick;
      check({vecs[i].name, " fetch"}, outs, ZERO_OUT);
      opcode = vecs[i].op; funct = vecs[i].fn; run = 1'b0;
      tick;
      opcode = 6'h3F; funct = 6'h3F;
      check({vecs[i].name, " decode"}, outs, ZERO_OUT);
      tick;
      check({vecs[i].name, " exec"}, outs, vecs[i].expExec);
      zero = vecs[i].z;
      tick;
      zero = ~vecs[i].z;
      check({vecs[i].name, " wb"}, outs, vecs[i].expWb);
      tick;
      check({vecs[i].name, " idle"}, outs, ZERO_OUT);
    end
    zero = 1'b0;

    // ori back-to-back with run high, then run dropped during the second EXEC.
    run = 1'b1; opcode = 6'h0D; funct = 6'h00;
    tick; tick; tick;
    check("ori1 exec", outs, 13'b0_0_0_0_0_1_0_001_0_0_0);
    tick;
    check("ori1 wb", outs, 13'b0_1_0_0_1_0_0_001_1_0_0);
    tick;
    check("ori2 fetch", outs, ZERO_OUT);
    tick; tick;
    check("ori2 exec", outs, 13'b0_0_0_0_0_1_0_001_0_0_0);
    run = 1'b0;
    tick;
    check("ori2 wb after run drop", outs, 13'b0_1_0_0_1_0_0_001_1_0_0);
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      tick;
      acc |= outs;
    end
    check("ori idle hold", acc, ZERO_OUT);

    // lw: ready on the 4th MEM cycle, 8 cycles FETCH..WB.
    run = 1'b1; opcode = 6'h23; funct = 6'h00;
    tick;
    run = 1'b0;
    tick; tick;
    check("lw exec", outs, 13'b0_0_0_0_0_1_0_010_0_0_0);
    for (int i = 1; i <= 4; i++) begin
      tick;
      check($sformatf("lw mem%0d", i), outs, 13'b0_0_0_0_0_1_0_010_0_0_0);
      if (i == 4) mem_ready = 1'b1;
    end
    tick;
    mem_ready = 1'b0;
    check("lw wb", outs, 13'b1_1_0_0_1_0_0_010_1_0_0);
    tick;
    check("lw idle", outs, ZERO_OUT);

    // sw: ready arrives on the last allowed MEM cycle, must complete.
    run = 1'b1; opcode = 6'h2B; funct = 6'h00;
    tick;
    run = 1'b0;
    tick; tick;
    for (int i = 1; i <= 8; i++) begin
      tick;
      check($sformatf("sw edge mem%0d", i), outs, 13'b0_0_1_0_0_1_0_010_0_0_0);
      if (i == 8) mem_ready = 1'b1;
    end
    tick;
    mem_ready = 1'b0;
    check("sw ready at expiry wb", outs, 13'b0_0_0_0_1_0_0_010_1_0_0);
    tick;

    // Reset in the middle of lw's MEM phase aborts it.
    run = 1'b1; opcode = 6'h23; funct = 6'h00;
    tick;
    run = 1'b0;
    tick; tick; tick;
    check("lw abort mem", outs, 13'b0_0_0_0_0_1_0_010_0_0_0);
    asyncReset;
    mem_ready = 1'b1;
    acc = '0;
    for (int i = 0; i < 6; i++) begin
      tick;
      acc |= outs;
    end
    mem_ready = 1'b0;
    check("no pulse after abort", acc, ZERO_OUT);

    // sw timeout: 8 MEM cycles, then TRAP with mem_timeout.
    run = 1'b1; opcode = 6'h2B; funct = 6'h00;
    tick;
    run = 1'b0;
    tick; tick;
    check("sw exec", outs, 13'b0_0_0_0_0_1_0_010_0_0_0);
    for (int i = 1; i <= 8; i++) begin
      tick;
      check($sformatf("sw mem%0d", i), outs, 13'b0_0_1_0_0_1_0_010_0_0_0);
    end
    tick;
    check("sw timeout trap", outs, 13'b0_0_0_0_0_0_0_000_0_0_1);
    run = 1'b1; mem_ready = 1'b1;
    acc = '0;
    for (int i = 0; i < 3; i++) begin
      tick;
      acc |= outs;
    end
    mem_ready = 1'b0;
    check("sw trap hold", acc, 13'b0_0_0_0_0_0_0_000_0_0_1);
    asyncReset;
    tick;
    check("idle after trap reset", outs, ZERO_OUT);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/mips_control_fsm.md
MIPS_CONTROL_FSM -- requirements
Module: mips_control_fsm

Interface
REQ-001 The block SHALL have parameter MEM_WAIT_MAX, default 8, giving the maximum cycles spent in MEM waiting for mem_ready.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port run, input, 1 bit: when high, new instructions are started.
REQ-005 The block SHALL have port opcode, input, 6 bits: instruction [31:26], valid during FETCH.
REQ-006 The block SHALL have port funct, input, 6 bits: instruction [5:0], valid during FETCH.
REQ-007 The block SHALL have port zero, input, 1 bit: the data_path ALU zero flag.
REQ-008 The block SHALL have port mem_ready, input, 1 bit: data memory access complete.
REQ-009 The block SHALL have ports MemaReg, enWrSram, enWriteMemory, ftePC, enablePC, fteALU and regDst, each output, 1 bit, with data_path meaning: writeback from memory, register-file write, memory write, PC source branch, PC load, ALU B immediate, and rd destination respectively.
REQ-010 The block SHALL have port ALUSelector, output, 3 bits: AND=000, OR=001, ADD=010, SUB=110, SLT=111.
REQ-011 The block SHALL have port instr_done, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have ports illegal and mem_timeout, each output, 1 bit: sticky fault flags.

Function
REQ-013 The FSM SHALL have states IDLE, FETCH, DECODE, EXEC, MEM, WB and TRAP.
REQ-014 Outputs SHALL be Moore: decoded only from the state register and the latched opcode, funct and zero registers; every output is 0 unless this section states otherwise.
REQ-015 IDLE SHALL go to FETCH when run=1.
REQ-016 FETCH SHALL last 1 cycle, latching opcode and funct on its exit edge, then go to DECODE.
REQ-017 DECODE SHALL go to TRAP if the opcode/funct pair is not supported, else to EXEC.
REQ-018 Supported set: R-type (opcode 0x00, funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A), addi 0x08, andi 0x0C, ori 0x0D, lw 0x23, sw 0x2B, beq 0x04.
REQ-019 In EXEC, R-type SHALL drive regDst=1, fteALU=0 and ALUSelector from funct.
REQ-020 In EXEC, addi, andi, ori, lw and sw SHALL drive fteALU=1 with ALU ADD, AND, OR, ADD and ADD respectively.
REQ-021 In EXEC, beq SHALL drive ALU SUB with fteALU=0 and latch zero into zero_q on the exit edge.
REQ-022 EXEC SHALL go to MEM for lw and sw, else to WB.
REQ-023 MEM SHALL hold the EXEC ALU controls; sw SHALL additionally assert enWriteMemory=1 for every MEM cycle.
REQ-024 MEM SHALL go to WB on the edge where mem_ready=1.
REQ-025 MEM SHALL go to TRAP with mem_timeout set if MEM_WAIT_MAX MEM cycles elapse without mem_ready; the wait counter clears on entry to MEM.
REQ-026 WB SHALL last exactly 1 cycle and assert enablePC=1 and instr_done=1.
REQ-027 In WB, R-type, I-type ALU ops and lw SHALL assert enWrSram=1; lw additionally asserts MemaReg=1; R-type keeps regDst=1; ALUSelector is held from EXEC.
REQ-028 In WB, beq SHALL drive ftePC=zero_q; sw SHALL drive no register write.
REQ-029 WB SHALL go to FETCH if run=1, else to IDLE; run is sampled only in IDLE and WB, so an instruction in flight always completes.
REQ-030 Latency SHALL be 4 cycles (FETCH to WB inclusive) for R, I and beq, and 5+N for lw/sw, where N is the number of mem_ready wait cycles.
REQ-031 TRAP SHALL hold all control outputs at 0 and keep illegal/mem_timeout high until reset.
REQ-032 A simultaneous mem_ready=1 and counter expiry SHALL be treated as ready, not timeout.

Reset
REQ-033 rst=0 SHALL asynchronously force state IDLE, set all outputs, latched opcode/funct, zero_q and the wait counter to 0, and clear illegal and mem_timeout.
REQ-034 Reset asserted mid-instruction SHALL abort it with no further enablePC or enWrSram pulse; after release the block restarts from IDLE.

Structure
REQ-035 A shared package mips_ctrl_pkg SHALL hold the state enumeration, opcode and funct constants, and ALUSelector codes.
REQ-036 One sub-module alu_decoder SHALL map latched opcode/funct to ALUSelector plus a legal flag.

Verification
REQ-037 run=1, add (op 0x00, fn 0x20) -> EXEC ALUSelector=010 regDst=1 fteALU=0; WB enWrSram=1 enablePC=1 instr_done=1; 4 cycles.
REQ-038 lw 0x23 with mem_ready high after 3 MEM cycles -> fteALU=1 ALU=010 through MEM; WB MemaReg=1 enWrSram=1; total 8 cycles.
REQ-039 beq 0x04 with zero=1 in EXEC -> WB ftePC=1 enablePC=1; repeat with zero=0 -> ftePC=0.
REQ-040 sw 0x2B with mem_ready never high, MEM_WAIT_MAX=8 -> enWriteMemory=1 for 8 cycles, then TRAP with mem_timeout=1 and enablePC never asserted.
REQ-041 opcode 0x3F -> TRAP after DECODE, illegal=1, outputs 0; rst low mid-TRAP -> IDLE with flags cleared.
REQ-042 run dropped during EXEC of ori 0x0D -> instruction completes (WB pulse), then IDLE.
